// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU blocks: FSM state encoding and
// the iteration-counter width helper.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    // Counter width for an n-step iteration; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/RippleCarryAdder.sv
// Existing N-bit ripple-carry adder shared by the ALU datapath.
// It has no carry-out port; callers widen the operands to recover the carry.
module RippleCarryAdder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);

    logic [N-1:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_sum
        assign sum[i] = a[i] ^ b[i] ^ c[i];
    end

    for (genvar i = 0; i < N - 1; i++) begin : g_carry
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier: one add through a shared
// ripple-carry adder per clock, N iterations per product.
//
// Handshake: start is sampled only in IDLE or DONE; an accepted start loads the
// operands and raises busy for exactly N cycles, then done pulses for one cycle
// while product holds A*B. start during RUN is ignored.
module seq_multiplier_ctrl
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   product,
    output mul_state_t       state
);

    localparam int CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    logic [N-1:0]     mcand;
    logic [N-1:0]     acc_hi;
    logic [N-1:0]     acc_lo;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     addend;
    logic [N:0]       sum;
    logic [2*N-1:0]   shifted;

    assign addend = acc_lo[0] ? mcand : '0;

    // Widened by one bit so the top sum bit carries the adder's carry-out.
    RippleCarryAdder #(
        .N (N + 1)
    ) u_adder (
        .a   ({1'b0, acc_hi}),
        .b   ({1'b0, addend}),
        .cin (1'b0),
        .sum (sum)
    );

    assign shifted = {sum, acc_lo[N-1:1]};

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state  <= ST_RUN;
                        mcand  <= A;
                        acc_hi <= '0;
                        acc_lo <= B;
                        cnt    <= '0;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_hi <= shifted[2*N-1:N];
                    acc_lo <= shifted[N-1:0];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        product <= shifted;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Self-checking bench for seq_multiplier_ctrl: table-driven products plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_seq_multiplier_ctrl;
    import alu_pkg::*;

    localparam int N = 8;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [N-1:0]     a_in;
    logic [N-1:0]     b_in;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;
    mul_state_t       state;

    logic [2*N-1:0]   exp_q[$];
    int               n_cmp = 0;
    int               n_err = 0;

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [2*N-1:0] p;
    } vec_t;

    vec_t vecs[8];

    seq_multiplier_ctrl #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A       (a_in),
        .B       (b_in),
        .busy    (busy),
        .done    (done),
        .product (product),
        .state   (state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Counts busy cycles until busy drops, checking product stays held.
    task automatic wait_done(output int cyc, input logic [2*N-1:0] held);
        cyc = 0;
        while (busy && cyc < TIMEOUT) begin
            check("product_stable_in_run", 32'(product), 32'(held));
            cyc++;
            tick();
        end
        if (cyc >= TIMEOUT) check("done_timeout", 32'(cyc), 32'(N));
    endtask

    task automatic pop_check(input string name);
        logic [2*N-1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, 32'(product), 32'(e));
        end
    endtask

    // Driver: one full operation from IDLE with a single-cycle start pulse.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] held;
        logic [2*N-1:0] e;
        int             cyc;
        held = product;
        e    = 16'(a) * 16'(b);
        a_in = a;
        b_in = b;
        start = 1'b1;
        exp_q.push_back(e);
        tick();
        start = 1'b0;
        a_in  = N'($urandom);
        b_in  = N'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(cyc, held);
        check("busy_cycles", 32'(cyc), 32'(N));
        check("done_high", 32'(done), 32'd1);
        check("busy_low_in_done", 32'(busy), 32'd0);
        pop_check("product");
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("product_hold", 32'(product), 32'(e));
    endtask

    initial begin
        int cyc;
        logic [2*N-1:0] held;

        vecs[0] = '{a: 8'd13,  b: 8'd11,  p: 16'd143};
        vecs[1] = '{a: 8'd255, b: 8'd255, p: 16'd65025};
        vecs[2] = '{a: 8'd0,   b: 8'd200, p: 16'd0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   p: 16'd0};
        vecs[4] = '{a: 8'd1,   b: 8'd255, p: 16'd255};
        for (int i = 5; i < 8; i++) begin
            vecs[i].a = N'($urandom_range(0, 255));
            vecs[i].b = N'($urandom_range(0, 255));
            vecs[i].p = 16'(vecs[i].a) * 16'(vecs[i].b);
        end

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        tick();
        tick();
        check("reset_state", 32'(state), 32'(ST_IDLE));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);

        // reset wins over start on the same edge
        a_in  = 8'd5;
        b_in  = 8'd5;
        start = 1'b1;
        tick();
        check("rst_priority_busy", 32'(busy), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        tick();
        check("idle_after_reset", 32'(state), 32'(ST_IDLE));

        // Table-driven products
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b);
            check("table_product", 32'(product), 32'(vecs[i].p));
            tick();
        end

        // start pulsed during RUN is ignored
        held  = product;
        a_in  = 8'd3;
        b_in  = 8'd5;
        start = 1'b1;
        exp_q.push_back(16'd15);
        tick();
        start = 1'b0;
        repeat (3) tick();
        a_in  = 8'd9;
        b_in  = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc, held);
        check("ignored_start_remaining_cycles", 32'(cyc), 32'(N - 4));
        check("ignored_start_done", 32'(done), 32'd1);
        pop_check("ignored_start_product");
        tick();
        check("ignored_start_idle", 32'(state), 32'(ST_IDLE));

        // start held high: back-to-back operations, one result every N+1 cycles
        held  = product;
        a_in  = 8'd7;
        b_in  = 8'd6;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(16'd42);
            wait_done(cyc, held);
            check("held_start_busy_cycles", 32'(cyc), 32'(N));
            check("held_start_done", 32'(done), 32'd1);
            check("held_start_busy_low", 32'(busy), 32'd0);
            pop_check("held_start_product");
            held = 16'd42;
            if (k == 2) start = 1'b0;
            tick();
            check("held_start_next_busy", 32'(busy), (k == 2) ? 32'd0 : 32'd1);
        end
        check("held_start_final_state", 32'(state), 32'(ST_IDLE));

        // Reset mid-run after a prior result of 42
        run_op(8'd7, 8'd6);
        a_in  = 8'd100;
        b_in  = 8'd100;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("mid_run_busy_before_reset", 32'(busy), 32'd1);
        check("mid_run_product_held", 32'(product), 32'd42);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state", 32'(state), 32'(ST_IDLE));
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        tick();
        check("abort_stays_idle", 32'(busy), 32'd0);
        run_op(8'd2, 8'd3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "global timeout");
    end

endmodule
